// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC register plus a DEPTH-entry {pc, instruction} FIFO with a valid/ready head.
// Optional macro IFETCH_BYPASS_EN forwards the ROM straight to decode while the queue is empty.
module ifetch_queue #(
   parameter int          INS_SIZE = 32,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [31:0]             rom_address,
   input  logic [INS_SIZE-1:0]     rom_out,
   output logic                    ins_valid,
   output logic [INS_SIZE-1:0]     ins_out,
   output logic [31:0]             ins_pc,
   input  logic                    ins_ready,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int              PW   = $clog2(DEPTH);
   localparam int              CW   = PW + 1;
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);

   logic [31:0]         fpc_q, fpc_d;
   logic [PW-1:0]       rdPtr_q, rdPtr_d;
   logic [PW-1:0]       wrPtr_q, wrPtr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [31:0]         pcMem  [DEPTH];
   logic [INS_SIZE-1:0] insMem [DEPTH];

   logic headValid;
   logic bypass;
   logic pop;
   logic push;
   logic bypassTake;
   logic bufWrite;
   logic bufRead;

`ifdef IFETCH_BYPASS_EN
   assign bypass = (count_q == '0) & ~redirect;
`else
   assign bypass = 1'b0;
`endif

   assign headValid   = (count_q != '0);
   assign ins_valid   = headValid | bypass;
   assign rom_address = fpc_q;
   assign count       = count_q;

   always_comb begin
      ins_out = '0;
      ins_pc  = '0;
      if (bypass) begin
         ins_out = rom_out;
         ins_pc  = fpc_q;
      end else if (headValid) begin
         ins_out = insMem[rdPtr_q];
         ins_pc  = pcMem[rdPtr_q];
      end
   end

   // A forwarded word taken by decode advances the PC but never touches the buffer.
   assign pop        = ins_valid & ins_ready;
   assign push       = ~redirect & ((count_q < FULL) | pop);
   assign bypassTake = bypass & ins_ready;
   assign bufWrite   = push & ~bypassTake;
   assign bufRead    = pop & ~bypassTake;

   always_comb begin
      fpc_d   = fpc_q;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (redirect) begin
         fpc_d   = redirect_pc;
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (push)     fpc_d   = fpc_q + 32'd1;
         if (bufWrite) wrPtr_d = wrPtr_q + PW'(1);
         if (bufRead)  rdPtr_d = rdPtr_q + PW'(1);
         if (bufWrite & ~bufRead)      count_d = count_q + CW'(1);
         else if (~bufWrite & bufRead) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q   <= RESET_PC;
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Buffer storage is left unreset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (bufWrite) begin
         pcMem[wrPtr_q]  <= fpc_q;
         insMem[wrPtr_q] <= rom_out;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue (default build): queue-based reference model plus directed literals.
module tb_ifetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] romAddress;
   logic [31:0] romOut;
   logic        insValid;
   logic [31:0] insOut;
   logic [31:0] insPc;
   logic        insReady;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [2:0]  count;

   int checkCount;
   int errorCount;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t      modelQ[$];
   logic [31:0] modelFpc;

   ifetch_queue #(
      .INS_SIZE(32),
      .DEPTH(DEPTH),
      .RESET_PC(32'd0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rom_address(romAddress),
      .rom_out(romOut),
      .ins_valid(insValid),
      .ins_out(insOut),
      .ins_pc(insPc),
      .ins_ready(insReady),
      .redirect(redirect),
      .redirect_pc(redirectPc),
      .count(count)
   );

   // Instruction ROM: word i holds i + 0x100.
   assign romOut = romAddress + 32'h100;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      modelFpc = 32'd0;
   endtask

   task automatic modelStep(input logic ready, input logic redir, input logic [31:0] rpc);
      int     sizeBefore;
      bit     mPop;
      entry_t e;
      sizeBefore = modelQ.size();
      mPop = (sizeBefore != 0) && ready;
      if (redir) begin
         modelQ.delete();
         modelFpc = rpc;
      end else begin
         if (mPop) e = modelQ.pop_front();
         if (sizeBefore < DEPTH || mPop) begin
            e.pc  = modelFpc;
            e.ins = modelFpc + 32'h100;
            modelQ.push_back(e);
            modelFpc = modelFpc + 32'd1;
         end
      end
   endtask

   task automatic checkOutput();
      logic [31:0] expPc;
      logic [31:0] expIns;
      logic [31:0] expValid;
      expPc    = 32'd0;
      expIns   = 32'd0;
      expValid = 32'd0;
      if (modelQ.size() != 0) begin
         expValid = 32'd1;
         expPc    = modelQ[0].pc;
         expIns   = modelQ[0].ins;
      end
      checkValue("model_valid", {31'd0, insValid}, expValid);
      checkValue("model_count", {29'd0, count}, 32'(modelQ.size()));
      checkValue("model_rom_address", romAddress, modelFpc);
      checkValue("model_ins_pc", insPc, expPc);
      checkValue("model_ins_out", insOut, expIns);
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
      insReady   = ready;
      redirect   = redir;
      redirectPc = rpc;
      @(posedge clk);
      modelStep(ready, redir, rpc);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      rst = 1'b1;
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput();
   endtask

   initial begin
      int readyPct;
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      insReady   = 1'b0;
      redirect   = 1'b0;
      redirectPc = 32'd0;
      modelReset();

      @(negedge clk);
      @(negedge clk);
      checkValue("reset_valid", {31'd0, insValid}, 32'd0);
      checkValue("reset_ins_out", insOut, 32'd0);
      checkValue("reset_ins_pc", insPc, 32'd0);
      checkValue("reset_rom_address", romAddress, 32'd0);
      checkValue("reset_count", {29'd0, count}, 32'd0);
      rst = 1'b0;

      $display("[TB] streaming with ready held high");
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("stream_first_valid", {31'd0, insValid}, 32'd1);
      checkValue("stream_first_pc", insPc, 32'd0);
      checkValue("stream_first_ins", insOut, 32'h100);
      for (int i = 1; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkValue("stream_pc", insPc, 32'(i));
         checkValue("stream_ins", insOut, 32'h100 + 32'(i));
         checkValue("stream_count", {29'd0, count}, 32'd1);
      end

      $display("[TB] stall until full, then release");
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'd0);
      checkValue("full_count", {29'd0, count}, 32'd4);
      checkValue("full_rom_address", romAddress, 32'd4);
      checkValue("full_ins_pc", insPc, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkValue("drain_pc", insPc, 32'(i));
         checkValue("drain_count", {29'd0, count}, 32'd4);
         checkValue("drain_rom_address", romAddress, 32'd4 + 32'(i));
      end

      $display("[TB] redirect with three queued entries");
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0);
      checkValue("pre_redirect_count", {29'd0, count}, 32'd3);
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkValue("redirect_count", {29'd0, count}, 32'd0);
      checkValue("redirect_valid", {31'd0, insValid}, 32'd0);
      checkValue("redirect_rom_address", romAddress, 32'h40);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("redirect_pc0", insPc, 32'h40);
      checkValue("redirect_ins0", insOut, 32'h140);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("redirect_pc1", insPc, 32'h41);

      $display("[TB] fetch PC wrap");
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
      checkValue("wrap_gap_valid", {31'd0, insValid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("wrap_pc0", insPc, 32'hFFFF_FFFE);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("wrap_pc1", insPc, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("wrap_pc2", insPc, 32'd0);
      checkValue("wrap_ins2", insOut, 32'h100);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("wrap_pc3", insPc, 32'd1);

      $display("[TB] asynchronous reset mid-cycle");
      doReset();
      applyStimulus(1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkValue("async_pre_count", {29'd0, count}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      checkValue("async_valid", {31'd0, insValid}, 32'd0);
      checkValue("async_rom_address", romAddress, 32'd0);
      checkValue("async_count", {29'd0, count}, 32'd0);
      checkValue("async_ins_pc", insPc, 32'd0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput();
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkValue("async_refetch_pc", insPc, 32'd0);

      $display("[TB] randomized traffic");
      readyPct = 50;
      for (int i = 0; i < 3000; i++) begin
         logic        rdy;
         logic        rdr;
         logic [31:0] rpc;
         if (i % 200 == 0) readyPct = $urandom_range(10, 100);
         rdy = ($urandom_range(1, 100) <= readyPct);
         rdr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else rpc = $urandom;
         applyStimulus(rdy, rdr, rpc);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
